// File: rtl/test_fifo_pkg.sv
// Shared types and default sizing for the single-port FIFO access scheduler.
// Pure declarations: no logic, no latency, no backpressure.
package test_fifo_pkg;

    typedef enum logic {GRANT_PUSH, GRANT_POP} grant_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/test_fifo_rr_arb2.sv
// Two-requester round-robin arbiter between push and pop. Ready is combinational.
// Under contention the side opposite to last_grant wins, so the two sides alternate.
module test_fifo_rr_arb2
    import test_fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic push_req,
    input  logic push_elig,
    input  logic pop_req,
    input  logic pop_elig,
    output logic push_rdy,
    output logic pop_rdy
);

    grant_e last_grant;
    logic   push_acc;
    logic   pop_acc;

    // A side stays ready unless the other side contends and has its turn.
    assign push_rdy = en & push_elig & ~(pop_req & pop_elig & (last_grant == GRANT_PUSH));
    assign pop_rdy  = en & pop_elig & ~(push_req & push_elig & (last_grant == GRANT_POP));

    assign push_acc = push_req & push_rdy;
    assign pop_acc  = pop_req & pop_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_PUSH;
        end else begin
            case (last_grant)
                GRANT_PUSH: if (pop_acc)  last_grant <= GRANT_POP;
                GRANT_POP:  if (push_acc) last_grant <= GRANT_PUSH;
                default:    last_grant <= GRANT_PUSH;
            endcase
        end
    end

endmodule

// File: rtl/test_fifo_access_arb.sv
// Schedules pushes and pops onto a single-port FIFO, one registered command per cycle.
// Command issues one cycle after accept; push stalls at full, pop stalls at empty.
module test_fifo_access_arb
    import test_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_rdy,
    input  logic             pop_req,
    output logic             pop_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             err,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] fifo_din,
    input  logic             fifo_mt,
    input  logic             fifo_full,
    input  logic             fifo_err,
    input  logic             fifo_rd_vld,
    input  logic [WIDTH-1:0] fifo_dout
);

    logic init_done;
    logic push_elig;
    logic pop_elig;
    logic push_acc;
    logic pop_acc;
    logic rd_prev;
    logic fault;

    assign push_elig = occupancy < CNT_W'(DEPTH);
    assign pop_elig  = occupancy != '0;

    test_fifo_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (init_done),
        .push_req  (push_vld),
        .push_elig (push_elig),
        .pop_req   (pop_req),
        .pop_elig  (pop_elig),
        .push_rdy  (push_rdy),
        .pop_rdy   (pop_rdy)
    );

    assign push_acc = push_vld & push_rdy;
    assign pop_acc  = pop_req & pop_rdy;

    // Read data arriving without a read issued the cycle before is a FIFO-side fault.
    assign fault = fifo_err
                 | (fifo_wr & fifo_full)
                 | (fifo_rd & fifo_mt)
                 | (fifo_rd_vld & ~rd_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_done <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_rd   <= 1'b0;
            fifo_din  <= '0;
            occupancy <= '0;
            rd_prev   <= 1'b0;
            err       <= 1'b0;
        end else begin
            init_done <= 1'b1;
            fifo_wr   <= push_acc;
            fifo_rd   <= pop_acc;
            rd_prev   <= fifo_rd;
            if (push_acc) begin
                fifo_din  <= push_data;
                occupancy <= occupancy + CNT_W'(1);
            end else if (pop_acc) begin
                occupancy <= occupancy - CNT_W'(1);
            end
            if (fault) begin
                err <= 1'b1;
            end
        end
    end

    assign rd_vld  = fifo_rd_vld;
    assign rd_data = fifo_dout;

endmodule

// File: tb/tb_test_fifo_access_arb.sv
// Directed bench for test_fifo_access_arb with a small behavioural single-port FIFO.
module tb_test_fifo_access_arb;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             push_vld;
    logic [WIDTH-1:0] push_data;
    logic             push_rdy;
    logic             pop_req;
    logic             pop_rdy;
    logic             rd_vld;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] occupancy;
    logic             err;
    logic             fifo_wr;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_mt;
    logic             fifo_full;
    logic             fifo_err;
    logic             fifo_rd_vld;
    logic [WIDTH-1:0] fifo_dout;

    logic             inj_rd_vld;
    logic             force_full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    test_fifo_access_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_vld    (push_vld),
        .push_data   (push_data),
        .push_rdy    (push_rdy),
        .pop_req     (pop_req),
        .pop_rdy     (pop_rdy),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .occupancy   (occupancy),
        .err         (err),
        .fifo_wr     (fifo_wr),
        .fifo_rd     (fifo_rd),
        .fifo_din    (fifo_din),
        .fifo_mt     (fifo_mt),
        .fifo_full   (fifo_full),
        .fifo_err    (fifo_err),
        .fifo_rd_vld (fifo_rd_vld),
        .fifo_dout   (fifo_dout)
    );

    // Behavioural single-port FIFO sharing the reset domain.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [5:0]       wp, rp;
    logic [6:0]       cnt;
    logic             m_rd_vld;
    logic [WIDTH-1:0] m_dout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0; rp <= '0; cnt <= '0; m_rd_vld <= 1'b0; m_dout <= '0;
        end else begin
            m_rd_vld <= 1'b0;
            if (fifo_wr && cnt < 7'(DEPTH)) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 6'd1;
                cnt     <= cnt + 7'd1;
            end else if (fifo_rd && cnt != 0) begin
                m_dout   <= mem[rp];
                m_rd_vld <= 1'b1;
                rp       <= rp + 6'd1;
                cnt      <= cnt - 7'd1;
            end
        end
    end

    assign fifo_mt     = (cnt == 0);
    assign fifo_full   = (cnt == 7'(DEPTH)) | force_full;
    assign fifo_err    = 1'b0;
    assign fifo_rd_vld = m_rd_vld | inj_rd_vld;
    assign fifo_dout   = m_dout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; push_vld = 1'b1; pop_req = 1'b1; push_data = 16'hFFFF;
        repeat (2) tick();
        total++;
        if ({fifo_wr, fifo_rd, fifo_din, occupancy, err, push_rdy, pop_rdy, rd_vld} !== '0) begin
            bad++;
            $display("FAIL reset_outputs wr=%b rd=%b din=%h occ=%0d err=%b prdy=%b poprdy=%b rdv=%b expected all 0",
                     fifo_wr, fifo_rd, fifo_din, occupancy, err, push_rdy, pop_rdy, rd_vld);
        end
        reset = 1'b0;
        pop_req = 1'b0;
        #1;
        total++;
        if (push_rdy !== 1'b0) begin
            bad++;
            $display("FAIL first_cycle_push_rdy got=%b expected=0", push_rdy);
        end
        tick();
        total++;
        if ({fifo_wr, fifo_rd, occupancy, err} !== '0) begin
            bad++;
            $display("FAIL idle_cycle wr=%b rd=%b occ=%0d err=%b expected 0", fifo_wr, fifo_rd, occupancy, err);
        end
        total++;
        if (push_rdy !== 1'b1) begin
            bad++;
            $display("FAIL cycle2_push_rdy got=%b expected=1", push_rdy);
        end
        push_vld = 1'b0;
        #1;
    endtask

    task automatic test_push_pop();
        push_vld = 1'b1; push_data = 16'h1234;
        tick();
        push_vld = 1'b0; pop_req = 1'b1;
        #1;
        total++;
        if ({fifo_wr, fifo_din, occupancy} !== {1'b1, 16'h1234, 7'd1}) begin
            bad++;
            $display("FAIL push_issue wr=%b din=%h occ=%0d expected wr=1 din=1234 occ=1", fifo_wr, fifo_din, occupancy);
        end
        total++;
        if (pop_rdy !== 1'b1) begin
            bad++;
            $display("FAIL pop_rdy_after_push got=%b expected=1", pop_rdy);
        end
        tick();
        pop_req = 1'b0;
        total++;
        if ({fifo_wr, fifo_rd, occupancy} !== {1'b0, 1'b1, 7'd0}) begin
            bad++;
            $display("FAIL pop_issue wr=%b rd=%b occ=%0d expected wr=0 rd=1 occ=0", fifo_wr, fifo_rd, occupancy);
        end
        tick();
        total++;
        if ({rd_vld, rd_data, err} !== {1'b1, 16'h1234, 1'b0}) begin
            bad++;
            $display("FAIL read_return vld=%b data=%h err=%b expected vld=1 data=1234 err=0", rd_vld, rd_data, err);
        end
    endtask

    task automatic test_full();
        push_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_data = 16'(16'h0A00 + i);
            tick();
        end
        #1;
        total++;
        if ({occupancy, push_rdy} !== {7'd64, 1'b0}) begin
            bad++;
            $display("FAIL full_block occ=%0d push_rdy=%b expected occ=64 push_rdy=0", occupancy, push_rdy);
        end
        push_vld = 1'b0; pop_req = 1'b1;
        #1;
        total++;
        if (pop_rdy !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_rdy got=%b expected=1", pop_rdy);
        end
        tick();
        pop_req = 1'b0; push_vld = 1'b1;
        #1;
        total++;
        if ({occupancy, push_rdy} !== {7'd63, 1'b1}) begin
            bad++;
            $display("FAIL after_full_pop occ=%0d push_rdy=%b expected occ=63 push_rdy=1", occupancy, push_rdy);
        end
        push_vld = 1'b0; pop_req = 1'b1;
        tick();
        total++;
        if ({rd_vld, rd_data} !== {1'b1, 16'h0A00}) begin
            bad++;
            $display("FAIL full_first_data vld=%b data=%h expected vld=1 data=0a00", rd_vld, rd_data);
        end
        repeat (52) tick();
        pop_req = 1'b0;
        repeat (2) tick();
        total++;
        if ({occupancy, err} !== {7'd10, 1'b0}) begin
            bad++;
            $display("FAIL drain_to_10 occ=%0d err=%b expected occ=10 err=0", occupancy, err);
        end
    endtask

    task automatic test_contention();
        push_vld = 1'b1; pop_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_data = 16'(16'hC000 + i);
            #1;
            total++;
            if ({push_rdy, pop_rdy} !== {(i % 2) == 0, (i % 2) == 1}) begin
                bad++;
                $display("FAIL alternate_grant cyc=%0d push_rdy=%b pop_rdy=%b expected push_rdy=%b", i, push_rdy, pop_rdy, (i % 2) == 0);
            end
            total++;
            if (fifo_wr && fifo_rd) begin
                bad++;
                $display("FAIL cmd_exclusive cyc=%0d wr=%b rd=%b expected not both", i, fifo_wr, fifo_rd);
            end
            tick();
        end
        push_vld = 1'b0; pop_req = 1'b0;
        total++;
        if ({fifo_wr, fifo_rd, occupancy} !== {1'b0, 1'b1, 7'd10}) begin
            bad++;
            $display("FAIL contention_end wr=%b rd=%b occ=%0d expected wr=0 rd=1 occ=10", fifo_wr, fifo_rd, occupancy);
        end
        tick();
    endtask

    task automatic test_empty();
        pop_req = 1'b1;
        repeat (10) tick();
        pop_req = 1'b0;
        repeat (2) tick();
        total++;
        if (occupancy !== 7'd0) begin
            bad++;
            $display("FAIL drain_to_empty occ=%0d expected 0", occupancy);
        end
        push_vld = 1'b1; pop_req = 1'b1; push_data = 16'h5A5A;
        #1;
        total++;
        if ({push_rdy, pop_rdy} !== 2'b10) begin
            bad++;
            $display("FAIL empty_grant push_rdy=%b pop_rdy=%b expected 1 0", push_rdy, pop_rdy);
        end
        tick();
        total++;
        if ({push_rdy, pop_rdy, occupancy} !== {2'b01, 7'd1}) begin
            bad++;
            $display("FAIL next_pop_grant push_rdy=%b pop_rdy=%b occ=%0d expected 0 1 occ=1", push_rdy, pop_rdy, occupancy);
        end
        tick();
        push_vld = 1'b0; pop_req = 1'b0;
        tick();
        total++;
        if ({rd_vld, rd_data, occupancy, err} !== {1'b1, 16'h5A5A, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL empty_return vld=%b data=%h occ=%0d err=%b expected 1 5a5a 0 0", rd_vld, rd_data, occupancy, err);
        end
        tick();
    endtask

    task automatic test_err();
        inj_rd_vld = 1'b1;
        tick();
        inj_rd_vld = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL spurious_rd_vld_err got=%b expected=1", err);
        end
        repeat (3) tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b expected=1", err);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({err, occupancy, fifo_wr, fifo_rd} !== '0) begin
            bad++;
            $display("FAIL err_reset err=%b occ=%0d wr=%b rd=%b expected all 0", err, occupancy, fifo_wr, fifo_rd);
        end
        tick();
        reset = 1'b0;
        tick();
        push_vld = 1'b1; push_data = 16'hBEEF;
        tick();
        push_vld = 1'b0; force_full = 1'b1;
        #1;
        total++;
        if ({fifo_wr, err} !== 2'b10) begin
            bad++;
            $display("FAIL pre_overflow wr=%b err=%b expected wr=1 err=0", fifo_wr, err);
        end
        tick();
        force_full = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL overflow_err got=%b expected=1", err);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; push_vld = 1'b0; push_data = '0; pop_req = 1'b0;
        inj_rd_vld = 1'b0; force_full = 1'b0;
        test_reset();
        test_push_pop();
        test_full();
        test_contention();
        test_empty();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
